// File: rtl/dma_bus_arbiter.sv
// Bus arbiter between cpu6502 and a block-copy DMA engine: holds the CPU via ready,
// waits until it is frozen on a read, then runs read/write byte pairs and releases the bus.
module dma_bus_arbiter #(
    parameter int LEN_W     = 8,
    parameter bit DST_FIXED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      cpu_address,
    input  logic             cpu_write,
    input  logic [7:0]       cpu_data_o,
    output logic             cpu_ready,
    output logic [7:0]       cpu_data_i,
    output logic [15:0]      mem_address,
    output logic             mem_write,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             dma_req,
    input  logic [15:0]      dma_src,
    input  logic [15:0]      dma_dst,
    input  logic [LEN_W-1:0] dma_len,
    output logic             dma_busy,
    output logic             dma_done
);

    typedef enum logic [2:0] {
        IDLE,
        STALL,
        READ,
        WRITE,
        RELEASE
    } state_t;

    state_t           state;
    logic [15:0]      src_ptr;
    logic [15:0]      dst_ptr;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       data_buf;

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cpu_ready <= 1'b1;
            dma_busy  <= 1'b0;
            dma_done  <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            cnt       <= '0;
            data_buf  <= '0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dma_req) begin
                        src_ptr   <= dma_src;
                        dst_ptr   <= dma_dst;
                        cnt       <= dma_len;
                        state     <= STALL;
                        cpu_ready <= 1'b0;
                        dma_busy  <= 1'b1;
                    end
                end
                STALL: begin
                    // The CPU only honours ready on reads; a write cycle means it is still running.
                    if (!cpu_write) state <= READ;
                end
                READ: begin
                    data_buf <= mem_rdata;
                    state    <= WRITE;
                end
                WRITE: begin
                    src_ptr <= src_ptr + 16'd1;
                    if (!DST_FIXED) dst_ptr <= dst_ptr + 16'd1;
                    cnt <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state    <= RELEASE;
                        dma_done <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                RELEASE: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b1;
                    dma_busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        mem_address = cpu_address;
        mem_write   = cpu_write;
        mem_wdata   = cpu_data_o;
        case (state)
            READ: begin
                mem_address = src_ptr;
                mem_write   = 1'b0;
            end
            WRITE: begin
                mem_address = dst_ptr;
                // A reset landing on a WRITE cycle abandons the transfer before that byte lands.
                mem_write   = !reset;
                mem_wdata   = data_buf;
            end
            default: ;
        endcase
    end

    assign cpu_data_i = mem_rdata;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Randomised bench for dma_bus_arbiter: a memory plus a simple CPU model around the DUT, with a
// byte-copy reference model feeding scoreboards of expected memory writes and busy/done windows.
module tb_dma_bus_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] cpu_address;
    logic        cpu_write;
    logic [7:0]  cpu_data_o;
    logic        cpu_ready;
    logic [7:0]  cpu_data_i;
    logic [15:0] mem_address;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_req;
    logic [15:0] dma_src;
    logic [15:0] dma_dst;
    logic [7:0]  dma_len;
    logic        dma_busy;
    logic        dma_done;

    logic [15:0] f_mem_address;
    logic        f_mem_write;
    logic [7:0]  f_mem_wdata;
    logic [7:0]  f_mem_rdata;
    logic        f_cpu_ready;
    logic [7:0]  f_cpu_data_i;
    logic        f_dma_req;
    logic [15:0] f_dma_src;
    logic [15:0] f_dma_dst;
    logic [7:0]  f_dma_len;
    logic        f_dma_busy;
    logic        f_dma_done;

    dma_bus_arbiter #(.LEN_W(8), .DST_FIXED(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_data_o(cpu_data_o),
        .cpu_ready(cpu_ready), .cpu_data_i(cpu_data_i),
        .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .dma_req(dma_req), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_done(dma_done)
    );

    dma_bus_arbiter #(.LEN_W(8), .DST_FIXED(1'b1)) u_fix (
        .clk(clk), .reset(reset),
        .cpu_address(16'hFFFC), .cpu_write(1'b0), .cpu_data_o(8'h00),
        .cpu_ready(f_cpu_ready), .cpu_data_i(f_cpu_data_i),
        .mem_address(f_mem_address), .mem_write(f_mem_write), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata),
        .dma_req(f_dma_req), .dma_src(f_dma_src), .dma_dst(f_dma_dst), .dma_len(f_dma_len),
        .dma_busy(f_dma_busy), .dma_done(f_dma_done)
    );

    // Real memory written by the DUT, and the reference image the model keeps in step.
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    assign mem_rdata = mem[mem_address];
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_wdata;

    // The fixed-destination instance reads a synthetic pattern keyed on the address.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    assign f_mem_rdata = pat(f_mem_address);

    typedef struct packed {logic [15:0] addr; logic [7:0] data;} wr_t;
    typedef struct packed {logic [15:0] addr; logic wr; logic [7:0] data;} op_t;
    typedef struct {int busy_len; int dones;} seg_t;

    wr_t  exp_wr[$];
    wr_t  f_exp[$];
    seg_t exp_seg[$];
    op_t  cpu_ops[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CPU model: reads advance only with ready=1, writes always advance.
    initial begin
        logic adv;
        op_t  op;
        cpu_address = 16'h0800;
        cpu_write   = 1'b0;
        cpu_data_o  = 8'h00;
        forever begin
            @(negedge clk);
            adv = (cpu_write === 1'b1) || (cpu_ready === 1'b1);
            @(posedge clk);
            #1;
            if (adv) begin
                if (cpu_ops.size() > 0) begin
                    op          = cpu_ops.pop_front();
                    cpu_address = op.addr;
                    cpu_write   = op.wr;
                    cpu_data_o  = op.data;
                end else begin
                    cpu_address = 16'h0800 + 16'($urandom_range(0, 255));
                    cpu_write   = 1'b0;
                    cpu_data_o  = 8'h00;
                end
            end
        end
    end

    // Monitor: memory writes against the queue, busy/done windows, and the CPU view of the bus.
    int  seg_len   = 0;
    int  seg_dones = 0;
    bit  prev_busy = 1'b0;
    int  f_dones   = 0;

    always @(negedge clk) begin
        wr_t  e;
        seg_t s;
        if (!reset && mem_write === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h at %0t", mem_address, mem_wdata, $time);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", mem_address, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
        if (dma_busy === 1'b1) begin
            seg_len++;
            if (dma_done === 1'b1) seg_dones++;
        end else if (prev_busy) begin
            if (exp_seg.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_busy_window len=%0d at %0t", seg_len, $time);
            end else begin
                s = exp_seg.pop_front();
                check("busy_cycles", seg_len, s.busy_len);
                check("done_pulses", seg_dones, s.dones);
            end
            seg_len   = 0;
            seg_dones = 0;
        end
        prev_busy = (dma_busy === 1'b1);
        if (!reset && cpu_ready === 1'b1) begin
            check("ready_addr_mux", mem_address, cpu_address);
            check("ready_write_mux", mem_write, cpu_write);
            if (cpu_write) check("ready_wdata_mux", mem_wdata, cpu_data_o);
            else           check("cpu_read_data", cpu_data_i, ref_mem[cpu_address]);
        end
        if (!reset && f_mem_write === 1'b1) begin
            if (f_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fixed_unexpected_write addr=%0h at %0t", f_mem_address, $time);
            end else begin
                e = f_exp.pop_front();
                check("fixed_wr_addr", f_mem_address, e.addr);
                check("fixed_wr_data", f_mem_wdata, e.data);
            end
        end
        if (f_dma_done === 1'b1) f_dones++;
    end

    // Reference copy: bytes move one at a time in ascending order, so overlap falls out naturally.
    task automatic model_copy(input logic [15:0] src, input logic [15:0] dst, input int n_wr);
        logic [15:0] a;
        logic [15:0] d;
        wr_t         w;
        for (int i = 0; i < n_wr; i++) begin
            a          = src + 16'(i);
            d          = dst + 16'(i);
            w.addr     = d;
            w.data     = ref_mem[a];
            ref_mem[d] = w.data;
            exp_wr.push_back(w);
        end
    endtask

    task automatic expect_seg(input int busy_len, input int dones);
        seg_t s;
        s.busy_len = busy_len;
        s.dones    = dones;
        exp_seg.push_back(s);
    endtask

    task automatic start_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len);
        @(posedge clk);
        #2;
        dma_src = src;
        dma_dst = dst;
        dma_len = len;
        dma_req = 1'b1;
        @(posedge clk);
        #2;
        dma_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (dma_busy === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        check("idle_timeout", got, 1'b1);
        @(negedge clk);
    endtask

    task automatic plain_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len);
        int n;
        n = (len == 8'd0) ? 256 : int'(len);
        model_copy(src, dst, n);
        expect_seg(1 + 2 * n + 1, 1);
        start_xfer(src, dst, len);
        wait_idle();
    endtask

    initial begin
        logic [7:0] v;
        op_t        op;
        wr_t        w;
        bit         got;
        int         ready_cnt;

        reset   = 1'b1;
        dma_req = 1'b0;
        dma_src = '0;
        dma_dst = '0;
        dma_len = '0;
        f_dma_req = 1'b0;
        f_dma_src = '0;
        f_dma_dst = '0;
        f_dma_len = '0;
        for (int i = 0; i < 65536; i++) begin
            v          = 8'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 1'b1);
        check("rst_dma_busy", dma_busy, 1'b0);
        check("rst_dma_done", dma_done, 1'b0);
        check("rst_mem_write", mem_write, cpu_write);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic copy with the CPU looping on reads.
        plain_xfer(16'h1000, 16'h2000, 8'd4);

        // Request lands on the first of three back-to-back push writes.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            op.addr          = 16'h01F2 - 16'(i);
            op.wr            = 1'b1;
            op.data          = 8'($urandom);
            w.addr           = op.addr;
            w.data           = op.data;
            ref_mem[op.addr] = op.data;
            cpu_ops.push_back(op);
            exp_wr.push_back(w);
        end
        model_copy(16'h3100, 16'h3200, 2);
        expect_seg(3 + 4 + 1, 1);
        start_xfer(16'h3100, 16'h3200, 8'd2);
        wait_idle();

        // Length 0 is a full 256-byte block; pointer wrap; overlapping forward copy.
        plain_xfer(16'h4000, 16'h5000, 8'd0);
        plain_xfer(16'hFFFE, 16'h00FF, 8'd3);
        plain_xfer(16'h3000, 16'h3001, 8'd8);

        for (int t = 0; t < 5; t++) begin
            plain_xfer(16'h2000 + 16'($urandom_range(0, 16'h9F00)),
                       16'h2000 + 16'($urandom_range(0, 16'h9F00)),
                       8'($urandom_range(1, 24)));
        end

        // Request held high: second transfer starts on the single IDLE cycle between them.
        model_copy(16'h2400, 16'h2600, 3);
        expect_seg(8, 1);
        model_copy(16'h2800, 16'h2A00, 2);
        expect_seg(6, 1);
        @(posedge clk);
        #2;
        dma_src = 16'h2400;
        dma_dst = 16'h2600;
        dma_len = 8'd3;
        dma_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dma_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b_first_done", got, 1'b1);
        dma_src   = 16'h2800;
        dma_dst   = 16'h2A00;
        dma_len   = 8'd2;
        ready_cnt = 0;
        got       = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dma_busy === 1'b1) dma_req = 1'b0;
            if (cpu_ready === 1'b1) ready_cnt++;
            if (dma_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        dma_req = 1'b0;
        check("b2b_second_done", got, 1'b1);
        check("b2b_ready_gap", ready_cnt, 1);
        wait_idle();

        // A request while busy is dropped, not queued.
        model_copy(16'h6800, 16'h6A00, 6);
        expect_seg(1 + 12 + 1, 1);
        start_xfer(16'h6800, 16'h6A00, 8'd6);
        repeat (3) @(posedge clk);
        #2;
        dma_src = 16'h7777;
        dma_dst = 16'h7800;
        dma_len = 8'd9;
        dma_req = 1'b1;
        @(posedge clk);
        #2;
        dma_req = 1'b0;
        wait_idle();

        // Reset on the second WRITE: only the first byte lands and no done pulse appears.
        model_copy(16'h6100, 16'h6000, 1);
        expect_seg(5, 0);
        start_xfer(16'h6100, 16'h6000, 8'd4);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("abort_cpu_ready", cpu_ready, 1'b1);
        check("abort_busy", dma_busy, 1'b0);
        check("abort_done", dma_done, 1'b0);
        check("abort_mem_write", mem_write, cpu_write);
        repeat (4) @(negedge clk);
        plain_xfer(16'hA000, 16'hB000, 8'd5);

        // Fixed-destination fill: five source bytes in order, all to one port address.
        for (int i = 0; i < 5; i++) begin
            w.addr = 16'hD400;
            w.data = pat(16'h7000 + 16'(i));
            f_exp.push_back(w);
        end
        @(posedge clk);
        #2;
        f_dma_src = 16'h7000;
        f_dma_dst = 16'hD400;
        f_dma_len = 8'd5;
        f_dma_req = 1'b1;
        @(posedge clk);
        #2;
        f_dma_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (f_dma_busy === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        check("fixed_idle", got, 1'b1);
        check("fixed_done_pulses", f_dones, 1);

        repeat (4) @(negedge clk);
        check("left_expected_writes", exp_wr.size(), 0);
        check("left_expected_windows", exp_seg.size(), 0);
        check("left_fixed_writes", f_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
